reg_read_stage: RTL and testbench

REG_READ_STAGE -- requirements
Module: reg_read_stage

---
 rtl/reg_read_stage.sv | 118 +++++++++++
 tb/tb_reg_read_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_stage.sv
// Register-read stage: 32x64 register file, busy-bit scoreboard and a single
// output entry to execute. Optional same-cycle writeback bypass: REG_READ_WB_BYPASS_EN.
module reg_read_stage (
  input  logic        clk,
  input  logic        reset,
  // decode side
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_wen,
  // writeback side
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  // execute side
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [63:0] ex_rs1val,
  output logic [63:0] ex_rs2val,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_wen,
  // scoreboard
  output logic [31:0] busy_vec
);

  logic [63:0] regs [32];
  logic [31:1] busy_q;

  logic        wb_clr;
  logic [31:0] busy_full;
  logic        rs1_hz, rs2_hz, rd_hz;
  logic        hazard;
  logic        slot_free;
  logic        issue;
  logic        issue_sets;
  logic [63:0] rs1_data, rs2_data;

  assign wb_clr    = wb_valid && (wb_rd != 5'd0);
  assign busy_full = {busy_q, 1'b0};
  assign busy_vec  = busy_full;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it holding a value (no inferred latch).
  always_comb begin
    rs1_hz   = 1'b0;
    rs2_hz   = 1'b0;
    rd_hz    = 1'b0;
    rs1_data = regs[id_rs1];
    rs2_data = regs[id_rs2];
`ifdef REG_READ_WB_BYPASS_EN
    // A busy bit being cleared this cycle is treated as already resolved,
    // with the committed value forwarded straight into the operand.
    if (wb_clr && wb_rd == id_rs1) rs1_data = wb_data;
    if (wb_clr && wb_rd == id_rs2) rs2_data = wb_data;
    rs1_hz = busy_full[id_rs1] && !(wb_clr && wb_rd == id_rs1);
    rs2_hz = busy_full[id_rs2] && !(wb_clr && wb_rd == id_rs2);
    rd_hz  = id_rd_wen && busy_full[id_rd] && !(wb_clr && wb_rd == id_rd);
`else
    rs1_hz = busy_full[id_rs1];
    rs2_hz = busy_full[id_rs2];
    rd_hz  = id_rd_wen && busy_full[id_rd];
`endif
  end

  assign hazard     = id_valid && (rs1_hz || rs2_hz || rd_hz);
  assign slot_free  = !ex_valid || ex_ready;
  assign id_ready   = !reset && slot_free && !hazard;
  assign issue      = id_valid && id_ready;
  assign issue_sets = issue && id_rd_wen && (id_rd != 5'd0);

  // NOTE: the register file is cleared by reset, so it is built from flops
  // rather than a RAM macro; a RAM array would normally not be reset.
  // x0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_clr) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // Set wins over clear when issue and writeback hit the same index.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_sets && id_rd == 5'(i))
          busy_q[i] <= 1'b1;
        else if (wb_clr && wb_rd == 5'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_rs1val <= '0;
      ex_rs2val <= '0;
      ex_rd     <= '0;
      ex_rd_wen <= 1'b0;
    end else if (issue) begin
      ex_valid  <= 1'b1;
      ex_rs1val <= rs1_data;
      ex_rs2val <= rs2_data;
      ex_rd     <= id_rd;
      ex_rd_wen <= id_rd_wen;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: directed issues push expected entries,
// a monitor pops and compares on each execute handshake.
module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rd_wen;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_rs1val, ex_rs2val;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;
  logic [31:0] busy_vec;

  typedef struct packed {
    logic [63:0] rs1val;
    logic [63:0] rs2val;
    logic [4:0]  rd;
    logic        wen;
  } entry_t;

  entry_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  reg_read_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1val(ex_rs1val), .ex_rs2val(ex_rs2val),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v1, input logic [63:0] v2,
                      input logic [4:0] rd, input logic wen);
    entry_t e;
    e.rs1val = v1; e.rs2val = v2; e.rd = rd; e.wen = wen;
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    step();
    wb_valid = 1'b0;
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic [63:0] v1, input logic [63:0] v2);
    bit ok = 1'b0;
    push(v1, v2, rd, wen);
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_wen = wen; id_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = id_ready;
      step();
    end
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    id_valid = 1'b0;
  endtask

  // Monitor: every execute handshake consumes one expected entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", {59'd0, ex_rd}, 64'hdead);
        end else begin
          e = exp_q.pop_front();
          check("sb_rs1val", ex_rs1val, e.rs1val);
          check("sb_rs2val", ex_rs2val, e.rs2val);
          check("sb_rd", {59'd0, ex_rd}, {59'd0, e.rd});
          check("sb_rd_wen", {63'd0, ex_rd_wen}, {63'd0, e.wen});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ex_ready = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_rd_wen = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("id_ready_in_reset", {63'd0, id_ready}, 64'd0);
    step();
    reset = 1'b0; id_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_busy_vec", {32'd0, busy_vec}, 64'd0);
    check("rst_ex_rs1val", ex_rs1val, 64'd0);
    check("rst_ex_rs2val", ex_rs2val, 64'd0);
    check("rst_ex_rd", {59'd0, ex_rd}, 64'd0);
    check("rst_ex_rd_wen", {63'd0, ex_rd_wen}, 64'd0);
    step();

    // Basic issue with preloaded operands
    wb(5'd1, 64'd5);
    wb(5'd2, 64'd7);
    issue(5'd1, 5'd2, 5'd3, 1'b1, 64'd5, 64'd7);
    @(negedge clk);
    check("issue_latency_ex_valid", {63'd0, ex_valid}, 64'd1);
    check("issue_busy_vec", {32'd0, busy_vec}, 64'h8);
    step();

    // RAW hazard on x3 resolved by writeback of 0xAB
    push(64'hAB, 64'd0, 5'd6, 1'b0);
    id_rs1 = 5'd3; id_rs2 = 5'd0; id_rd = 5'd6; id_rd_wen = 1'b0; id_valid = 1'b1;
    @(negedge clk);
    check("raw_stall_0", {63'd0, id_ready}, 64'd0);
    step();
    @(negedge clk);
    check("raw_stall_1", {63'd0, id_ready}, 64'd0);
    step();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'hAB;
    @(negedge clk);
`ifdef REG_READ_WB_BYPASS_EN
    check("raw_wb_cycle_ready", {63'd0, id_ready}, 64'd1);
    step();
    wb_valid = 1'b0; id_valid = 1'b0;
`else
    check("raw_wb_cycle_ready", {63'd0, id_ready}, 64'd0);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("raw_after_wb_ready", {63'd0, id_ready}, 64'd1);
    step();
    id_valid = 1'b0;
`endif
    @(negedge clk);
    check("raw_ex_valid", {63'd0, ex_valid}, 64'd1);
    check("raw_busy_vec", {32'd0, busy_vec}, 64'd0);
    step();

    // Backpressure: three stalled cycles, then back-to-back issue
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd7, 1'b1, 64'd5, 64'd7);
    push(64'd7, 64'd5, 5'd8, 1'b1);
    id_rs1 = 5'd2; id_rs2 = 5'd1; id_rd = 5'd8; id_rd_wen = 1'b1; id_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_id_ready", {63'd0, id_ready}, 64'd0);
      check("bp_ex_valid", {63'd0, ex_valid}, 64'd1);
      check("bp_rs1val", ex_rs1val, 64'd5);
      check("bp_rs2val", ex_rs2val, 64'd7);
      check("bp_rd", {59'd0, ex_rd}, 64'd7);
      check("bp_rd_wen", {63'd0, ex_rd_wen}, 64'd1);
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    check("b2b_id_ready", {63'd0, id_ready}, 64'd1);
    step();
    id_valid = 1'b0;
    @(negedge clk);
    check("b2b_ex_valid", {63'd0, ex_valid}, 64'd1);
    check("b2b_busy_vec", {32'd0, busy_vec}, 64'h180);
    step();
    wb(5'd7, 64'h77);
    wb(5'd8, 64'h88);
    @(negedge clk);
    check("wb_clear_busy_vec", {32'd0, busy_vec}, 64'd0);
    step();

    // x0 handling; x5 was only written during reset so it reads 0
    wb(5'd0, 64'hFFFF);
    issue(5'd0, 5'd5, 5'd0, 1'b1, 64'd0, 64'd0);
    @(negedge clk);
    check("x0_busy_vec", {32'd0, busy_vec}, 64'd0);
    step();
    issue(5'd8, 5'd7, 5'd0, 1'b1, 64'h88, 64'h77);

    // Same-cycle read of a non-busy index being written back
`ifdef REG_READ_WB_BYPASS_EN
    push(64'h99, 64'd0, 5'd0, 1'b0);
`else
    push(64'd0, 64'd0, 5'd0, 1'b0);
`endif
    id_rs1 = 5'd9; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_wen = 1'b0; id_valid = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
    @(negedge clk);
    check("wb_nonbusy_ready", {63'd0, id_ready}, 64'd1);
    step();
    id_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("wb_nonbusy_busy_vec", {32'd0, busy_vec}, 64'd0);
    step();

    // WAW hazard on busy rd
    issue(5'd0, 5'd0, 5'd10, 1'b1, 64'd0, 64'd0);
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd10; id_rd_wen = 1'b1; id_valid = 1'b1;
    @(negedge clk);
    check("waw_stall", {63'd0, id_ready}, 64'd0);
    step();
    id_valid = 1'b0;
    wb(5'd10, 64'h1010);

    // Issue-set beats writeback-clear on the same index, then reset mid-transfer
    ex_ready = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd4; id_rd_wen = 1'b1; id_valid = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h44;
    step();
    id_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("setprio_busy_vec", {32'd0, busy_vec}, 64'h10);
    check("setprio_ex_valid", {63'd0, ex_valid}, 64'd1);
    check("setprio_ex_rd", {59'd0, ex_rd}, 64'd4);
    step();
    reset = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h1234;
    step();
    reset = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("midrst_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("midrst_busy_vec", {32'd0, busy_vec}, 64'd0);
    check("midrst_ex_rd", {59'd0, ex_rd}, 64'd0);
    check("midrst_id_ready", {63'd0, id_ready}, 64'd1);
    step();
    ex_ready = 1'b1;
    issue(5'd1, 5'd4, 5'd0, 1'b0, 64'd0, 64'd0);

    repeat (3) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
